corebootstrap_boot_sequencer: RTL and testbench
===============================================

// Module: corebootstrap_boot_sequencer
// PURPOSE
//  Top-level sequencer for the bootstrap SPI reader/checksum datapath. Resets and starts the reader,
//  watches copy progress with a stall watchdog and qualifies the checksum result. Retries a failed
//  copy up to MAX_RETRIES times, then releases the processor reset or latches a boot failure.
//  Sits between system reset and the processor reset input; the reader's HRESETN is driven from ~rdr_reset.
// PARAMETERS
//  CKSUM_EN        0        1: wait for cksum_done and honour CKSUM_ERR; 0: skip CHECK.
//  MAX_RETRIES     2        extra copy attempts after the first (0..15).
//  TIMEOUT_CYCLES  1000000  max HCLKs between progress events (rd_data_avail) in COPY; >=2.
//  RDR_RST_CYCLES  4        HCLKs rdr_reset is held per attempt; >=1.
//  CPU_RST_HOLD    16       HCLKs cpu_reset_n stays low after copy success, before release; >=1.
// PORTS
//  HCLK           in   1  clock, free-running.
//  HRESET         in   1  asynchronous reset, active-high.
//  SW_DEBUG_MODE  in   1  bypass copy, sampled in IDLE only.
//  rd_data_avail  in   1  reader word-valid pulse, used as the progress event.
//  rd_all_done    in   1  reader finished all words (level).
//  cksum_done     in   1  checksum compare complete (level).
//  CKSUM_ERR      in   1  checksum mismatch, valid while cksum_done=1.
//  rdr_reset      out  1  active-high reset to reader/checksum blocks.
//  cpu_reset_n    out  1  processor reset, active-low.
//  boot_done      out  1  processor released (sticky until HRESET).
//  boot_fail      out  1  retries exhausted, processor held (sticky until HRESET).
//  retry_cnt      out  4  retries consumed so far.
//  seq_state      out  3  current state encoding (debug).
// BEHAVIOUR
//  Interface: one clock HCLK; HRESET asynchronous, active-high. All state and outputs are registered.
//  Reset values: state=IDLE, rdr_reset=1, cpu_reset_n=0, boot_done=0, boot_fail=0, retry_cnt=0, counters=0.
//  States and encodings: IDLE=0, RDR_RST=1, COPY=2, CHECK=3, HOLD=4, DONE=5, FAIL=6.
//  IDLE: one cycle after reset deassertion.
//   - SW_DEBUG_MODE=1 -> HOLD; rdr_reset stays 1 for the whole boot.
//   - else -> RDR_RST.
//  RDR_RST: rdr_reset=1 for exactly RDR_RST_CYCLES cycles, then -> COPY.
//   - rdr_reset deasserts on the same edge that enters COPY.
//   - The watchdog counter is cleared on entry.
//  COPY: rdr_reset=0.
//   - Watchdog increments each cycle and clears on any cycle with rd_data_avail=1.
//   - rd_all_done=1 -> CHECK if CKSUM_EN=1, else HOLD.
//   - Watchdog reaching TIMEOUT_CYCLES-1 with no progress -> ERR path.
//   - If rd_all_done and timeout occur in the same cycle, rd_all_done wins.
//  CHECK: waits for cksum_done=1, with the same watchdog (no progress clear).
//   - CKSUM_ERR=0 when sampled -> HOLD.
//   - CKSUM_ERR=1 when sampled -> ERR path.
//   - CKSUM_ERR is sampled only in the cycle where cksum_done=1.
//  ERR path (transition, not a state):
//   - retry_cnt<MAX_RETRIES -> retry_cnt+1, -> RDR_RST.
//   - else -> FAIL.
//   - retry_cnt saturates and never wraps.
//  HOLD: cpu_reset_n=0 for CPU_RST_HOLD cycles, then -> DONE.
//  DONE: terminal. cpu_reset_n=1, boot_done=1, both set on the edge entering DONE. rdr_reset=1.
//  FAIL: terminal. boot_fail=1, cpu_reset_n=0, rdr_reset=1.
//  Terminal states are left only by HRESET.
//   - Inputs are ignored in DONE and FAIL; SW_DEBUG_MODE changes after IDLE are ignored.
//  Reset mid-operation: HRESET at any point returns all outputs to reset values immediately (async).
//   - A new boot starts from IDLE after deassertion.
//  Counter widths: $clog2(param+1), so terminal counts never overflow.
//  Latency: no-debug, no-error boot from HRESET deassert to cpu_reset_n=1 is
//   1 + RDR_RST_CYCLES + (COPY cycles) + [CHECK cycles] + CPU_RST_HOLD.
// TESTING
//  1. CKSUM_EN=0, pulse rd_data_avail every 10 cycles x100, then rd_all_done.
//     -> rdr_reset low 4 cycles after IDLE; cpu_reset_n rises 16 cycles after rd_all_done;
//        boot_done=1; retry_cnt=0.
//  2. SW_DEBUG_MODE=1 at reset release.
//     -> rdr_reset never deasserts; cpu_reset_n=1 exactly 1+16 cycles after reset deassert.
//  3. CKSUM_EN=1, cksum_done with CKSUM_ERR=1 on attempts 1 and 2, clean on attempt 3.
//     -> two RDR_RST pulses; retry_cnt=2; boot_done=1.
//  4. TIMEOUT_CYCLES=50, no rd_data_avail after entering COPY.
//     -> retry after 50 cycles each time; after 3 attempts boot_fail=1, cpu_reset_n=0, seq_state=6.
//  5. rd_all_done asserted in the same cycle the watchdog expires -> CHECK/HOLD taken, no retry.
//  6. HRESET asserted mid-COPY (retry_cnt=1)
//     -> rdr_reset=1, cpu_reset_n=0, retry_cnt=0 immediately; clean boot succeeds after release.

Source files
------------

// File: rtl/corebootstrap_boot_sequencer.sv
// Boot sequencer: resets and starts the SPI reader, watches copy progress with a stall
// watchdog, qualifies the checksum, retries failed copies, then releases or fails the CPU.
module corebootstrap_boot_sequencer #(
  parameter bit CKSUM_EN       = 1'b0,
  parameter int MAX_RETRIES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RDR_RST_CYCLES = 4,
  parameter int CPU_RST_HOLD   = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       SW_DEBUG_MODE,
  input  logic       rd_data_avail,
  input  logic       rd_all_done,
  input  logic       cksum_done,
  input  logic       CKSUM_ERR,
  output logic       rdr_reset,
  output logic       cpu_reset_n,
  output logic       boot_done,
  output logic       boot_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] seq_state
);

  localparam int RW = $clog2(RDR_RST_CYCLES + 1);
  localparam int HW = $clog2(CPU_RST_HOLD + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST   = RW'(RDR_RST_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(CPU_RST_HOLD - 1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RDR_RST = 3'd1,
    S_COPY    = 3'd2,
    S_CHECK   = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   rst_cnt, rst_cnt_nx;
  logic [HW-1:0]   hold_cnt, hold_cnt_nx;
  logic [WW-1:0]   wdog, wdog_nx;
  logic [3:0]      retry_nx;
  logic            err;

  assign seq_state = state;

  always_comb begin
    state_nx    = state;
    rst_cnt_nx  = rst_cnt;
    hold_cnt_nx = hold_cnt;
    wdog_nx     = wdog;
    retry_nx    = retry_cnt;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        if (SW_DEBUG_MODE) begin
          state_nx    = S_HOLD;
          hold_cnt_nx = '0;
        end else begin
          state_nx   = S_RDR_RST;
          rst_cnt_nx = '0;
        end
      end
      S_RDR_RST: begin
        if (rst_cnt == RST_LAST) begin
          state_nx = S_COPY;
          wdog_nx  = '0;
        end else begin
          rst_cnt_nx = rst_cnt + RW'(1);
        end
      end
      S_COPY: begin
        wdog_nx = rd_data_avail ? '0 : wdog + WW'(1);
        // Completion beats a watchdog expiry landing in the same cycle.
        if (rd_all_done) begin
          wdog_nx = '0;
          if (CKSUM_EN) begin
            state_nx = S_CHECK;
          end else begin
            state_nx    = S_HOLD;
            hold_cnt_nx = '0;
          end
        end else if (!rd_data_avail && wdog == WDOG_LAST) begin
          err = 1'b1;
        end
      end
      S_CHECK: begin
        wdog_nx = wdog + WW'(1);
        if (cksum_done) begin
          if (CKSUM_ERR) begin
            err = 1'b1;
          end else begin
            state_nx    = S_HOLD;
            hold_cnt_nx = '0;
          end
        end else if (wdog == WDOG_LAST) begin
          err = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx = S_DONE;
        end else begin
          hold_cnt_nx = hold_cnt + HW'(1);
        end
      end
      S_DONE, S_FAIL: ;
      default: state_nx = S_IDLE;
    endcase

    // Error path: retry while budget remains; retry_cnt only moves below the cap, so it cannot wrap.
    if (err) begin
      if (retry_cnt < RETRY_MAX) begin
        retry_nx   = retry_cnt + 4'd1;
        state_nx   = S_RDR_RST;
        rst_cnt_nx = '0;
      end else begin
        state_nx = S_FAIL;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      rst_cnt  <= '0;
      hold_cnt <= '0;
      wdog     <= '0;
    end else begin
      state    <= state_nx;
      rst_cnt  <= rst_cnt_nx;
      hold_cnt <= hold_cnt_nx;
      wdog     <= wdog_nx;
    end
  end

  // Outputs are registered from the next state so they change on the edge that enters each state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rdr_reset   <= 1'b1;
      cpu_reset_n <= 1'b0;
      boot_done   <= 1'b0;
      boot_fail   <= 1'b0;
      retry_cnt   <= 4'd0;
    end else begin
      rdr_reset   <= !(state_nx == S_COPY || state_nx == S_CHECK);
      cpu_reset_n <= (state_nx == S_DONE);
      boot_done   <= (state_nx == S_DONE);
      boot_fail   <= (state_nx == S_FAIL);
      retry_cnt   <= retry_nx;
    end
  end

endmodule

// File: tb/tb_corebootstrap_boot_sequencer.sv
// Bench for corebootstrap_boot_sequencer: a reactive reader model drives two instances
// (checksum off / on) through a table of boot scenarios with hand-computed outcomes.
module tb_corebootstrap_boot_sequencer;

  localparam logic [1:0] M_GOOD  = 2'd0;
  localparam logic [1:0] M_ERR   = 2'd1;
  localparam logic [1:0] M_STALL = 2'd2;
  localparam logic [1:0] M_RACE  = 2'd3;

  typedef struct {
    string          name;
    bit             sel;
    bit             debug;
    logic [3:0][1:0] modes;
    int             n;
    int             exp_term;
    int             exp_att;
    int             exp_retry;
    int             exp_done;
    int             exp_fail;
    int             exp_state;
  } scen_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic SW_DEBUG_MODE = 1'b0;
  logic rd_data_avail = 1'b0;
  logic rd_all_done = 1'b0;
  logic cksum_done = 1'b0;
  logic cksum_err = 1'b0;

  logic       a_rdr_reset, a_cpu_reset_n, a_boot_done, a_boot_fail;
  logic [3:0] a_retry_cnt;
  logic [2:0] a_seq_state;
  logic       b_rdr_reset, b_cpu_reset_n, b_boot_done, b_boot_fail;
  logic [3:0] b_retry_cnt;
  logic [2:0] b_seq_state;

  bit              cur_sel = 1'b0;
  logic [3:0][1:0] cur_modes = '0;
  int              cur_n = 0;
  int              num_att = 0;
  int              rdr_t = 0;
  logic            prev_rdr = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  scen_t tbl[10];

  logic       o_rdr_reset, o_cpu_reset_n, o_boot_done, o_boot_fail;
  logic [3:0] o_retry_cnt;
  logic [2:0] o_seq_state;
  assign o_rdr_reset   = cur_sel ? b_rdr_reset   : a_rdr_reset;
  assign o_cpu_reset_n = cur_sel ? b_cpu_reset_n : a_cpu_reset_n;
  assign o_boot_done   = cur_sel ? b_boot_done   : a_boot_done;
  assign o_boot_fail   = cur_sel ? b_boot_fail   : a_boot_fail;
  assign o_retry_cnt   = cur_sel ? b_retry_cnt   : a_retry_cnt;
  assign o_seq_state   = cur_sel ? b_seq_state   : a_seq_state;

  corebootstrap_boot_sequencer #(.CKSUM_EN(1'b0), .TIMEOUT_CYCLES(50)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .SW_DEBUG_MODE(SW_DEBUG_MODE),
    .rd_data_avail(rd_data_avail), .rd_all_done(rd_all_done),
    .cksum_done(cksum_done), .CKSUM_ERR(cksum_err),
    .rdr_reset(a_rdr_reset), .cpu_reset_n(a_cpu_reset_n), .boot_done(a_boot_done),
    .boot_fail(a_boot_fail), .retry_cnt(a_retry_cnt), .seq_state(a_seq_state)
  );

  corebootstrap_boot_sequencer #(.CKSUM_EN(1'b1), .TIMEOUT_CYCLES(50)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .SW_DEBUG_MODE(SW_DEBUG_MODE),
    .rd_data_avail(rd_data_avail), .rd_all_done(rd_all_done),
    .cksum_done(cksum_done), .CKSUM_ERR(cksum_err),
    .rdr_reset(b_rdr_reset), .cpu_reset_n(b_cpu_reset_n), .boot_done(b_boot_done),
    .boot_fail(b_boot_fail), .retry_cnt(b_retry_cnt), .seq_state(b_seq_state)
  );

  // Clock / reset
  always #5 HCLK = ~HCLK;

  // Reader model: runs while rdr_reset is low, behaviour chosen per attempt.
  always @(negedge HCLK) begin
    int idx;
    if (HRESET) begin
      num_att = 0;
      rdr_t = 0;
      prev_rdr = 1'b1;
      rd_data_avail = 1'b0;
      rd_all_done = 1'b0;
      cksum_done = 1'b0;
      cksum_err = 1'b0;
    end else begin
      if (prev_rdr && !o_rdr_reset) num_att = num_att + 1;
      prev_rdr = o_rdr_reset;
      rd_data_avail = 1'b0;
      rd_all_done = 1'b0;
      cksum_done = 1'b0;
      cksum_err = 1'b0;
      if (o_rdr_reset) begin
        rdr_t = 0;
      end else begin
        rdr_t = rdr_t + 1;
        idx = (num_att > 4) ? 3 : num_att - 1;
        case (cur_modes[idx])
          M_GOOD: begin
            rd_data_avail = (rdr_t % 10 == 0) && (rdr_t <= 10 * cur_n);
            rd_all_done = (rdr_t >= 10 * cur_n + 10);
            cksum_done = (rdr_t >= 10 * cur_n + 13);
          end
          M_ERR: begin
            rd_all_done = (rdr_t >= 5);
            cksum_done = (rdr_t >= 8);
            cksum_err = (rdr_t >= 8);
          end
          M_RACE: begin
            rd_all_done = (rdr_t >= 50);
            cksum_done = (rdr_t >= 53);
          end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_next(input string name, input logic [31:0] act);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0d expected <nothing queued>", name, act);
    end else begin
      exp = exp_q.pop_front();
      check(name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic apply_reset(input scen_t s);
    @(posedge HCLK); #2;
    HRESET = 1'b1;
    cur_sel = s.sel;
    cur_modes = s.modes;
    cur_n = s.n;
    SW_DEBUG_MODE = s.debug;
    repeat (3) @(posedge HCLK);
    #2 HRESET = 1'b0;
  endtask

  task automatic run_scenario(input scen_t s);
    int cyc;
    int t_term;
    apply_reset(s);
    cyc = 0;
    t_term = -1;
    while (t_term < 0 && cyc < 2000) begin
      @(posedge HCLK);
      cyc++;
      @(negedge HCLK);
      if (cyc == 1) SW_DEBUG_MODE = ~s.debug;
      if (o_cpu_reset_n || o_boot_fail) t_term = cyc;
    end
    repeat (8) @(negedge HCLK);
    exp_q.push_back(32'(s.exp_term));
    exp_q.push_back(32'(s.exp_att));
    exp_q.push_back(32'(s.exp_retry));
    exp_q.push_back(32'(s.exp_done));
    exp_q.push_back(32'(s.exp_fail));
    exp_q.push_back(32'(s.exp_done));
    exp_q.push_back(32'(s.exp_state));
    check_next({s.name, "/term_cycle"}, 32'(t_term));
    check_next({s.name, "/attempts"}, 32'(num_att));
    check_next({s.name, "/retry_cnt"}, 32'(o_retry_cnt));
    check_next({s.name, "/boot_done"}, 32'(o_boot_done));
    check_next({s.name, "/boot_fail"}, 32'(o_boot_fail));
    check_next({s.name, "/cpu_reset_n"}, 32'(o_cpu_reset_n));
    check_next({s.name, "/seq_state"}, 32'(o_seq_state));
  endtask

  initial begin
    int cyc;
    // modes packed as {attempt3, attempt2, attempt1, attempt0}
    tbl[0] = '{"good_nock",   1'b0, 1'b0, {M_GOOD, M_GOOD, M_GOOD, M_GOOD},      100, 1031, 1, 0, 1, 0, 5};
    tbl[1] = '{"debug_nock",  1'b0, 1'b1, {M_GOOD, M_GOOD, M_GOOD, M_GOOD},      0,   17,   0, 0, 1, 0, 5};
    tbl[2] = '{"debug_ck",    1'b1, 1'b1, {M_GOOD, M_GOOD, M_GOOD, M_GOOD},      0,   17,   0, 0, 1, 0, 5};
    tbl[3] = '{"err_err_ok",  1'b1, 1'b0, {M_GOOD, M_GOOD, M_ERR, M_ERR},        3,   88,   3, 2, 1, 0, 5};
    tbl[4] = '{"stall3_ck",   1'b1, 1'b0, {M_STALL, M_STALL, M_STALL, M_STALL},  0,   163,  3, 2, 0, 1, 6};
    tbl[5] = '{"stall3_nock", 1'b0, 1'b0, {M_STALL, M_STALL, M_STALL, M_STALL},  0,   163,  3, 2, 0, 1, 6};
    tbl[6] = '{"race_nock",   1'b0, 1'b0, {M_RACE, M_RACE, M_RACE, M_RACE},      0,   71,   1, 0, 1, 0, 5};
    tbl[7] = '{"race_ck",     1'b1, 1'b0, {M_RACE, M_RACE, M_RACE, M_RACE},      0,   74,   1, 0, 1, 0, 5};
    tbl[8] = '{"stall_ok_ck", 1'b1, 1'b0, {M_GOOD, M_GOOD, M_GOOD, M_STALL},     2,   108,  2, 1, 1, 0, 5};
    tbl[9] = '{"err_nock",    1'b0, 1'b0, {M_ERR, M_ERR, M_ERR, M_ERR},          0,   26,   1, 0, 1, 0, 5};

    // Reset values on both instances
    repeat (3) @(negedge HCLK);
    check("rst/a_rdr_reset", 32'(a_rdr_reset), 1);
    check("rst/a_cpu_reset_n", 32'(a_cpu_reset_n), 0);
    check("rst/a_boot_done", 32'(a_boot_done), 0);
    check("rst/a_boot_fail", 32'(a_boot_fail), 0);
    check("rst/a_retry_cnt", 32'(a_retry_cnt), 0);
    check("rst/a_seq_state", 32'(a_seq_state), 0);
    check("rst/b_rdr_reset", 32'(b_rdr_reset), 1);
    check("rst/b_cpu_reset_n", 32'(b_cpu_reset_n), 0);
    check("rst/b_boot_done", 32'(b_boot_done), 0);
    check("rst/b_boot_fail", 32'(b_boot_fail), 0);
    check("rst/b_retry_cnt", 32'(b_retry_cnt), 0);
    check("rst/b_seq_state", 32'(b_seq_state), 0);

    for (int i = 0; i < 10; i++) run_scenario(tbl[i]);

    // Reader reset window: rdr_reset held for cycles 1..4, low from cycle 5.
    apply_reset(tbl[0]);
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    check("rdr_window/cycle4", 32'(o_rdr_reset), 1);
    @(negedge HCLK);
    check("rdr_window/cycle5", 32'(o_rdr_reset), 0);
    check("rdr_window/state", 32'(o_seq_state), 2);

    // Asynchronous reset in the middle of the second copy attempt.
    apply_reset(tbl[8]);
    cyc = 0;
    while (cyc < 80) begin
      @(posedge HCLK);
      cyc++;
    end
    @(negedge HCLK);
    check("midrst/pre_retry_cnt", 32'(o_retry_cnt), 1);
    check("midrst/pre_seq_state", 32'(o_seq_state), 2);
    check("midrst/pre_rdr_reset", 32'(o_rdr_reset), 0);
    #1 HRESET = 1'b1;
    #1;
    check("midrst/rdr_reset", 32'(o_rdr_reset), 1);
    check("midrst/cpu_reset_n", 32'(o_cpu_reset_n), 0);
    check("midrst/retry_cnt", 32'(o_retry_cnt), 0);
    check("midrst/seq_state", 32'(o_seq_state), 0);
    check("midrst/boot_done", 32'(o_boot_done), 0);
    run_scenario(tbl[8]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
